// File: rtl/fp_unpack_pkg.sv
// fp_unpack_pkg: class codes and format-derivation helpers shared by the
// unpack stage and the downstream FP adder/multiplier blocks.
package fp_unpack_pkg;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_QNAN = 3'd4,
    FP_SNAN = 3'd5
  } fp_class_e;

  // Packed operand width: sign + exponent field + stored mantissa.
  function automatic int fp_width(input int exp_w, input int mant_w);
    return 1 + exp_w + mant_w;
  endfunction

  // IEEE-754 exponent bias.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero count of a W-bit vector (returns W for all-zero input).
module fp_lzc #(
  parameter  int W  = 10,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] count
);

  logic found;

  // Scan from the MSB, counting zeros until the first set bit.
  always_comb begin
    count = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      count = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: splits a pair of packed IEEE-754 operands into sign,
// unbiased exponent, explicit-hidden-bit significand and class code, behind a
// 2-entry output skid buffer with a registered in_ready.
// Build option: FP_UNPACK_NORMALIZE_EN adds a register stage and normalizes
// subnormal significands (hidden bit forced to 1, exponent extended below
// the normal range).
module fp_operand_unpack
  import fp_unpack_pkg::*;
#(
  parameter  int EXP_W  = 5,
  parameter  int MANT_W = 10,
  localparam int FW     = fp_width(EXP_W, MANT_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FW-1:0]           op_a,
  input  logic [FW-1:0]           op_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_a,
  output logic                    sign_b,
  output logic signed [EXP_W+1:0] exp_a,
  output logic signed [EXP_W+1:0] exp_b,
  output logic [MANT_W:0]         mant_a,
  output logic [MANT_W:0]         mant_b,
  output logic [2:0]              class_a,
  output logic [2:0]              class_b
);

  localparam int BIAS = fp_bias(EXP_W);
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MANT_W + 1;

  typedef struct packed {
    logic                 sign;
    logic signed [EW-1:0] exp;
    logic [MW-1:0]        mant;
    fp_class_e            cls;
  } operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } pair_t;

  // Classify one packed operand; subnormals keep the minimum exponent here.
  function automatic operand_t unpack(input logic [FW-1:0] op);
    operand_t           r;
    logic [EXP_W-1:0]   e;
    logic [MANT_W-1:0]  m;
    r      = '0;
    e      = op[FW-2 -: EXP_W];
    m      = op[MANT_W-1:0];
    r.sign = op[FW-1];
    if (e == '0) begin
      if (m == '0) begin
        r.cls = FP_ZERO;
      end else begin
        r.cls  = FP_SUB;
        r.exp  = EW'(1 - BIAS);
        r.mant = {1'b0, m};
      end
    end else if (&e) begin
      r.exp  = EW'(BIAS + 1);
      r.mant = {1'b1, m};
      if (m == '0)         r.cls = FP_INF;
      else if (m[MANT_W-1]) r.cls = FP_QNAN;
      else                 r.cls = FP_SNAN;
    end else begin
      r.cls  = FP_NORM;
      r.exp  = EW'(int'(e) - BIAS);
      r.mant = {1'b1, m};
    end
    return r;
  endfunction

  logic [1:0] cnt, cnt_next;
  pair_t      e0, e1;
  pair_t      push_data;
  logic       push, pop, accept, full_next;

  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef FP_UNPACK_NORMALIZE_EN
  localparam int LZW = $clog2(MANT_W + 1);

  // Shift a subnormal so its leading one lands in the hidden-bit position.
  function automatic operand_t normalize(input operand_t r, input logic [LZW-1:0] lz);
    operand_t n;
    int       shift;
    n     = r;
    shift = int'(lz) + 1;
    if (r.cls == FP_SUB) begin
      n.mant = r.mant << shift;
      n.exp  = EW'(1 - BIAS - shift);
    end
    return n;
  endfunction

  logic          s1_v, s1_v_next;
  logic [FW-1:0] s1_a, s1_b;
  logic [LZW-1:0] lz_a, lz_b;

  fp_lzc #(.W(MANT_W)) u_lzc_a (.d(s1_a[MANT_W-1:0]), .count(lz_a));
  fp_lzc #(.W(MANT_W)) u_lzc_b (.d(s1_b[MANT_W-1:0]), .count(lz_b));

  // The input stage drains into the buffer whenever a slot exists or frees up.
  assign push      = s1_v && ((cnt != 2'd2) || pop);
  assign s1_v_next = accept ? 1'b1 : (push ? 1'b0 : s1_v);
  assign full_next = s1_v_next && (cnt_next == 2'd2);

  // Decode and normalize the staged raw operands on their way into the buffer.
  always_comb begin
    push_data.a = normalize(unpack(s1_a), lz_a);
    push_data.b = normalize(unpack(s1_b), lz_b);
  end

  // Input register stage holding the raw operand pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else begin
      s1_v <= s1_v_next;
      if (accept) begin
        s1_a <= op_a;
        s1_b <= op_b;
      end
    end
  end
`else
  assign push      = accept;
  assign full_next = (cnt_next == 2'd2);

  // Decode straight from the ports into the buffer.
  always_comb begin
    push_data.a = unpack(op_a);
    push_data.b = unpack(op_b);
  end
`endif

  // Buffer occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves cnt_next unassigned (no latch).
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + 2'd1;
      2'b01:   cnt_next = cnt - 2'd1;
      default: ;
    endcase
  end

  // Two-entry skid buffer with e0 as the head; in_ready registered from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are reset because they drive the data outputs, which must read 0 after reset.
      cnt      <= '0;
      e0       <= '0;
      e1       <= '0;
      in_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      cnt      <= cnt_next;
      in_ready <= !full_next;
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
        end
        2'b01: e0 <= e1;
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign sign_a  = e0.a.sign;
  assign exp_a   = e0.a.exp;
  assign mant_a  = e0.a.mant;
  assign class_a = e0.a.cls;
  assign sign_b  = e0.b.sign;
  assign exp_b   = e0.b.exp;
  assign mant_b  = e0.b.mant;
  assign class_b = e0.b.cls;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// tb_fp_operand_unpack: scoreboard bench for fp_operand_unpack (binary16 main
// instance plus a binary32 instance). Honours FP_UNPACK_NORMALIZE_EN.
module tb_fp_operand_unpack;

`ifdef FP_UNPACK_NORMALIZE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct { int sign; int exp; int mant; int cls; } op_exp_t;
  typedef struct { op_exp_t a; op_exp_t b; int ready_cyc; } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              in_valid, in_ready, out_valid, out_ready;
  logic [15:0]       op_a, op_b;
  logic              sign_a, sign_b;
  logic signed [6:0] exp_a, exp_b;
  logic [10:0]       mant_a, mant_b;
  logic [2:0]        class_a, class_b;

  logic              in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0]       op_a32, op_b32;
  logic              sign_a32, sign_b32;
  logic signed [9:0] exp_a32, exp_b32;
  logic [23:0]       mant_a32, mant_b32;
  logic [2:0]        class_a32, class_b32;

  item_t q[$];
  int    cyc = 0;
  int    last_pop = -10;
  int    n_cmp = 0;
  int    n_fail = 0;

  fp_operand_unpack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .mant_a(mant_a), .mant_b(mant_b), .class_a(class_a), .class_b(class_b)
  );

  fp_operand_unpack #(.EXP_W(8), .MANT_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .op_a(op_a32), .op_b(op_b32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sign_a(sign_a32), .sign_b(sign_b32), .exp_a(exp_a32), .exp_b(exp_b32),
    .mant_a(mant_a32), .mant_b(mant_b32), .class_a(class_a32), .class_b(class_b32)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d items still expected", q.size());
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic op_exp_t mk(input int s, input int e, input int m, input int c);
    op_exp_t r;
    r.sign = s; r.exp = e; r.mant = m; r.cls = c;
    return r;
  endfunction

  // Reference decode from the numeric rules of the format.
  function automatic op_exp_t ref_unpack(input longint op, input int ew, input int mw);
    op_exp_t r;
    int bias, emax, e, m;
    bias   = (1 << (ew - 1)) - 1;
    emax   = (1 << ew) - 1;
    e      = int'((op >> mw) & longint'(emax));
    m      = int'(op & ((longint'(1) << mw) - 1));
    r.sign = int'((op >> (ew + mw)) & 1);
    if (e == 0 && m == 0) begin
      r.cls = 0; r.exp = 0; r.mant = 0;
    end else if (e == 0) begin
      r.cls = 1; r.exp = 1 - bias; r.mant = m;
`ifdef FP_UNPACK_NORMALIZE_EN
      while (r.mant < (1 << mw)) begin
        r.mant = r.mant * 2;
        r.exp  = r.exp - 1;
      end
`endif
    end else if (e == emax) begin
      r.exp  = bias + 1;
      r.mant = (1 << mw) + m;
      if (m == 0)                   r.cls = 3;
      else if (m >= (1 << (mw - 1))) r.cls = 4;
      else                          r.cls = 5;
    end else begin
      r.cls = 2; r.exp = e - bias; r.mant = (1 << mw) + m;
    end
    return r;
  endfunction

  function automatic op_exp_t ref16(input logic [15:0] x);
    return ref_unpack(longint'(x), 5, 10);
  endfunction

  function automatic logic [15:0] rand_op();
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       e = '0;
      1:       e = '1;
      default: e = 5'($urandom_range(1, 30));
    endcase
    case ($urandom_range(0, 3))
      0:       m = '0;
      1:       m = 10'h200 | 10'($urandom);
      2:       m = 10'(1 << $urandom_range(0, 9));
      default: m = 10'($urandom);
    endcase
    return {s, e, m};
  endfunction

  task automatic cmp_op(input string tag, input int s, input int e, input int m,
                        input int c, input op_exp_t x);
    check({tag, "_sign"},  s, x.sign);
    check({tag, "_exp"},   e, x.exp);
    check({tag, "_mant"},  m, x.mant);
    check({tag, "_class"}, c, x.cls);
  endtask

  // Monitor: every cycle the head of the queue must be presented exactly when due.
  always @(negedge clk) begin
    int exp_c;
    if (!rst) begin
      if (q.size() != 0) begin
        exp_c = (q[0].ready_cyc > last_pop + 1) ? q[0].ready_cyc : last_pop + 1;
        if (cyc >= exp_c) check("out_valid_due",   int'(out_valid), 1);
        else              check("out_valid_early", int'(out_valid), 0);
        if (out_valid) begin
          cmp_op("a", int'(sign_a), int'(exp_a), int'(mant_a), int'(class_a), q[0].a);
          cmp_op("b", int'(sign_b), int'(exp_b), int'(mant_b), int'(class_b), q[0].b);
          if (out_ready) begin
            void'(q.pop_front());
            last_pop = cyc;
          end
        end
      end else begin
        check("out_valid_spurious", int'(out_valid), 0);
      end
    end
  end

  // One cycle of stimulus; records the expected pair when a transfer will occur.
  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input op_exp_t ea, input op_exp_t eb, input bit ordy, output bit acc);
    item_t it;
    @(posedge clk); #1;
    in_valid  = v;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    acc = v && in_ready && !rst;
    if (acc) begin
      it.a = ea; it.b = eb; it.ready_cyc = cyc + LAT;
      q.push_back(it);
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, 16'h0, 16'h0, mk(0, 0, 0, 0), mk(0, 0, 0, 0), ordy, acc);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input op_exp_t ea, input op_exp_t eb);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 50) begin
      drive(1'b1, a, b, ea, eb, 1'b1, acc);
      t++;
    end
    check("send_accept", int'(acc), 1);
  endtask

  task automatic wait_empty();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      idle(1'b1);
      t++;
    end
    check("drain", q.size(), 0);
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test32(input logic [31:0] a, input logic [31:0] b, input op_exp_t ea);
    op_exp_t eb;
    int t;
    eb = ref_unpack(longint'(b), 8, 23);
    @(posedge clk); #1;
    in_valid32 = 1'b1; op_a32 = a; op_b32 = b;
    check("in_ready32", int'(in_ready32), 1);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    t = 0;
    while (!out_valid32 && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    check("out_valid32", int'(out_valid32), 1);
    check("latency32", t, LAT - 1);
    cmp_op("a32", int'(sign_a32), int'(exp_a32), int'(mant_a32), int'(class_a32), ea);
    cmp_op("b32", int'(sign_b32), int'(exp_b32), int'(mant_b32), int'(class_b32), eb);
    @(posedge clk); #1;
    check("drained32", int'(out_valid32), 0);
  endtask

  initial begin
    logic [15:0] a, b;
    logic [15:0] sa[8], sb[8];
    bit          acc, saw_low;
    int          k, n_acc;
    op_exp_t     sub_exp;

    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; op_a32 = '0; op_b32 = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   int'(in_ready), 0);
    check("rst_out_valid",  int'(out_valid), 0);
    check("rst_sign_a",     int'(sign_a), 0);
    check("rst_exp_a",      int'(exp_a), 0);
    check("rst_mant_a",     int'(mant_a), 0);
    check("rst_class_a",    int'(class_a), 0);
    check("rst_mant_b",     int'(mant_b), 0);
    check("rst_in_ready32", int'(in_ready32), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", int'(in_ready), 1);

    // Directed decodes, each isolated so the latency check is exact.
    send(16'h3C00, 16'h8000, mk(0, 0, 'h400, 2), mk(1, 0, 0, 0));
    wait_empty();
`ifdef FP_UNPACK_NORMALIZE_EN
    sub_exp = mk(0, -24, 'h400, 1);
`else
    sub_exp = mk(0, -14, 'h001, 1);
`endif
    send(16'h0001, 16'h3C00, sub_exp, mk(0, 0, 'h400, 2));
    wait_empty();
    send(16'h7C00, 16'h7E00, mk(0, 16, 'h400, 3), mk(0, 16, 'h600, 4));
    wait_empty();
    send(16'h7C01, 16'hFC00, mk(0, 16, 'h401, 5), mk(1, 16, 'h400, 3));
    wait_empty();

    // Stream of 8 pairs with the consumer stalled for cycles 3-5.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'h3C00 + 16'(i);
      sb[i] = 16'hC000 + 16'(i * 3);
    end
    saw_low = 1'b0;
    k = 0;
    n_acc = 0;
    while (n_acc < 8 && k < 100) begin
      drive(1'b1, sa[n_acc], sb[n_acc], ref16(sa[n_acc]), ref16(sb[n_acc]),
            !(k >= 3 && k <= 5), acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) n_acc++;
      k++;
    end
    check("stream_accepted", n_acc, 8);
    check("in_ready_fell", int'(saw_low), 1);
    wait_empty();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      b = rand_op();
      drive($urandom_range(0, 9) < 7, a, b, ref16(a), ref16(b), $urandom_range(0, 9) < 6, acc);
    end
    wait_empty();

    // Mid-stream reset with two pairs in flight.
    drive(1'b1, 16'h4000, 16'h4200, ref16(16'h4000), ref16(16'h4200), 1'b0, acc);
    check("inflight1_accept", int'(acc), 1);
    drive(1'b1, 16'h4400, 16'h4600, ref16(16'h4400), ref16(16'h4600), 1'b0, acc);
    check("inflight2_accept", int'(acc), 1);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready",  int'(in_ready), 0);
    @(posedge clk); #1;
    check("midrst_in_ready_next", int'(in_ready), 1);
    repeat (6) idle(1'b1);
    send(16'h3555, 16'h0200, ref16(16'h3555), ref16(16'h0200));
    wait_empty();

    // binary32 instance.
    test32(32'h3F800000, 32'h80000000, mk(0, 0, 'h800000, 2));
    test32(32'h00000001, 32'h7FC00000, ref_unpack(longint'(32'h00000001), 8, 23));
    test32(32'hFF800000, 32'h7F800001, ref_unpack(longint'(32'hFF800000), 8, 23));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
